// File: rtl/lsu_mem_stage.sv
// Load/store stage behind the RV32I ALU: funct3/alignment checks, one outstanding req/ack data-memory access, extended load data to writeback.
// Optional LSU_TIMEOUT_EN: abort an access with rsp_err after MAX_WAIT cycles without dmem_ack.
module lsu_mem_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  offset_q, offset_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;

  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_lane_wdata;
  logic [31:0] load_lane;
  logic [31:0] load_data;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);
  logic [WaitW-1:0] wait_q, wait_d;
`endif

  // Request decode: legality, alignment and store lane placement from the incoming address.
  always_comb begin
    req_bad        = 1'b0;
    req_be         = 4'b1111;
    req_lane_wdata = 32'h0;
    unique case (req_funct3)
      3'b000: begin
        req_be         = 4'b0001 << req_addr[1:0];
        req_lane_wdata = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        req_bad        = req_addr[0];
        req_be         = 4'b0011 << {req_addr[1], 1'b0};
        req_lane_wdata = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        req_bad        = |req_addr[1:0];
        req_lane_wdata = req_wdata;
      end
      3'b100, 3'b101: begin
        req_bad = req_we | (req_funct3[0] & req_addr[0]);
      end
      default: req_bad = 1'b1;
    endcase
    if (!req_we) begin
      req_be         = 4'b1111;
      req_lane_wdata = 32'h0;
    end
  end

  // Load lane select and extension, using the offset/funct3 latched at accept.
  always_comb begin
    load_lane = dmem_rdata >> {offset_q, 3'b000};
    load_data = load_lane;
    unique case (funct3_q)
      3'b000:  load_data = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b001:  load_data = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b100:  load_data = {24'h0, load_lane[7:0]};
      3'b101:  load_data = {16'h0, load_lane[15:0]};
      default: load_data = load_lane;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    offset_d     = offset_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
`ifdef LSU_TIMEOUT_EN
    wait_d       = wait_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          offset_d = req_addr[1:0];
          funct3_d = req_funct3;
          we_d     = req_we;
          if (req_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d      = ACCESS;
            dmem_req_d   = 1'b1;
            dmem_we_d    = req_we;
            dmem_addr_d  = {req_addr[31:2], 2'b00};
            dmem_be_d    = req_be;
            dmem_wdata_d = req_lane_wdata;
`ifdef LSU_TIMEOUT_EN
            wait_d       = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d     = RESP;
          dmem_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : load_data;
`ifdef LSU_TIMEOUT_EN
        end else if (wait_q == WaitLast) begin
          // Give up on the bus; any ack arriving later lands outside ACCESS and is dropped.
          state_d     = RESP;
          dmem_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          wait_d = wait_q + 1'b1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_be_q    <= 4'h0;
      dmem_wdata_q <= 32'h0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      offset_q     <= 2'b00;
      funct3_q     <= 3'b000;
      we_q         <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      wait_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      offset_q     <= offset_d;
      funct3_q     <= funct3_d;
      we_q         <= we_d;
`ifdef LSU_TIMEOUT_EN
      wait_q       <= wait_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule
